// File: rtl/alu_pipe_pkg.sv
// Shared types for the handshaked ALU: operation codes, sequencing states
// and the condition-register field layout.
package alu_pipe_pkg;

    localparam int OP_W = 5;
    localparam int CR_W = 4;

    typedef enum logic [OP_W-1:0] {
        ADD    = 5'd0,
        SUB    = 5'd1,
        NEG    = 5'd2,
        CMP    = 5'd3,
        CMPL   = 5'd4,
        AND    = 5'd5,
        OR     = 5'd6,
        XOR    = 5'd7,
        NAND   = 5'd8,
        NOR    = 5'd9,
        EQV    = 5'd10,
        ANDC   = 5'd11,
        ORC    = 5'd12,
        POPCNT = 5'd13,
        PRTY   = 5'd14,
        CNTLZ  = 5'd15,
        DIVW   = 5'd16,
        DIVWU  = 5'd17
    } Alu_pipe_op;

    typedef enum logic [1:0] {
        IDLE,
        DIV_SETUP,
        DIV_ITER,
        DIV_DONE
    } Alu_pipe_state;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
    } Cr_field;

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == DIVW) || (op == DIVWU);
    endfunction

endpackage

// File: rtl/alu_pipe_div_seq.sv
// Restoring word divider, one quotient bit per cycle. The parent sequences it
// through capture (start), magnitude setup and WIDTH iteration cycles.
module div_seq
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             start_i,
    input  logic             setup_i,
    input  logic             iter_i,
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quo_o,
    output logic             exc_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d, neg_q, neg_d, exc_q, exc_d;
    logic [WIDTH:0]   shifted, diff;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn & v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        sgn_d = sgn_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        exc_d = exc_q;
        if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            sgn_d = sgn_i;
        end
        if (setup_i) begin
            rem_d = '0;
            quo_d = mag(a_q, sgn_q);
            dvs_d = mag(b_q, sgn_q);
            neg_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            // MIN / -1 overflows the signed range, so it is flagged with divide-by-zero
            exc_d = (b_q == '0) |
                    (sgn_q & (a_q == {1'b1, {(WIDTH-1){1'b0}}}) & (&b_q));
            cnt_d = CW'(WIDTH - 1);
        end
        if (iter_i) begin
            cnt_d = cnt_q - 1'b1;
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sgn_q <= sgn_d;
        dvs_q <= dvs_d;
        quo_q <= quo_d;
        rem_q <= rem_d;
        cnt_q <= cnt_d;
        neg_q <= neg_d;
        exc_q <= exc_d;
    end

    assign done_o = iter_i & (cnt_q == '0);
    assign exc_o  = exc_q;
    assign quo_o  = exc_q ? '0 : (neg_q ? (~quo_q + 1'b1) : quo_q);

endmodule

// File: rtl/alu_pipe.sv
// Handshaked integer ALU: single-cycle ops land in the output register at the
// accept edge; word divides run through the iterative divider first.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ov,
    output logic [CR_W-1:0]  out_cr,
    output logic [TAG_W-1:0] out_tag
);

    Alu_pipe_state    state_q, state_d;
    Alu_pipe_op       op;
    logic             accept, is_div, load_single, load_div;
    logic             div_start, div_setup, div_iter, div_done, div_exc;
    logic [WIDTH-1:0] div_quo;

    logic [WIDTH-1:0] add_x, add_y;
    logic             add_c;
    logic [WIDTH:0]   add_sum;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout, is_cmp;
    Cr_field          alu_cr;

    logic             valid_q, valid_d, cout_q, cout_d, ov_q, ov_d;
    logic [WIDTH-1:0] res_q, res_d;
    Cr_field          cr_q, cr_d;
    logic [TAG_W-1:0] tag_q, tag_d, div_tag_q, div_tag_d;

    function automatic Cr_field cr_of(input logic [WIDTH-1:0] r, input logic so);
        Cr_field c;
        c.lt = r[WIDTH-1];
        c.gt = ~r[WIDTH-1] & (|r);
        c.eq = ~(|r);
        c.so = so;
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] popcnt_bytes(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic [7:0]       c;
        r = '0;
        for (int j = 0; j < WIDTH/8; j++) begin
            c = '0;
            for (int k = 0; k < 8; k++) c = c + {7'b0, v[8*j+k]};
            r[8*j +: 8] = c;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] byte_parity(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             p;
        p = 1'b0;
        for (int j = 0; j < WIDTH/8; j++) p = p ^ v[8*j];
        r    = '0;
        r[0] = p;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] count_lz(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = WIDTH-1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      r = r + 1'b1;
            end
        end
        return r;
    endfunction

    assign op  = Alu_pipe_op'(in_op);
    assign a_s = in_a;
    assign b_s = in_b;

    // One shared adder serves ADD, SUB (a + ~b + 1) and NEG (~a + 1)
    always_comb begin
        add_x = in_a;
        add_y = in_b;
        add_c = in_cin;
        case (op)
            SUB: begin
                add_y = ~in_b;
                add_c = 1'b1;
            end
            NEG: begin
                add_x = ~in_a;
                add_y = '0;
                add_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};

    always_comb begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_cout  = add_sum[WIDTH];
        is_cmp    = 1'b0;
        alu_cr    = '0;
        case (op)
            CMP: begin
                is_cmp    = 1'b1;
                alu_res   = '0;
                alu_cout  = 1'b0;
                alu_cr.lt = a_s < b_s;
                alu_cr.gt = a_s > b_s;
                alu_cr.eq = in_a == in_b;
            end
            CMPL: begin
                is_cmp    = 1'b1;
                alu_res   = '0;
                alu_cout  = 1'b0;
                alu_cr.lt = in_a < in_b;
                alu_cr.gt = in_a > in_b;
                alu_cr.eq = in_a == in_b;
            end
            AND:    begin alu_res = in_a & in_b;          alu_cout = 1'b0; end
            OR:     begin alu_res = in_a | in_b;          alu_cout = 1'b0; end
            XOR:    begin alu_res = in_a ^ in_b;          alu_cout = 1'b0; end
            NAND:   begin alu_res = ~(in_a & in_b);       alu_cout = 1'b0; end
            NOR:    begin alu_res = ~(in_a | in_b);       alu_cout = 1'b0; end
            EQV:    begin alu_res = ~(in_a ^ in_b);       alu_cout = 1'b0; end
            ANDC:   begin alu_res = in_a & ~in_b;         alu_cout = 1'b0; end
            ORC:    begin alu_res = in_a | ~in_b;         alu_cout = 1'b0; end
            POPCNT: begin alu_res = popcnt_bytes(in_a);   alu_cout = 1'b0; end
            PRTY:   begin alu_res = byte_parity(in_a);    alu_cout = 1'b0; end
            CNTLZ:  begin alu_res = count_lz(in_a);       alu_cout = 1'b0; end
            default: ;
        endcase
        if (!is_cmp) alu_cr = cr_of(alu_res, 1'b0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (div_start) state_d = DIV_SETUP;
                DIV_SETUP: state_d = DIV_ITER;
                DIV_ITER:  if (div_done) state_d = DIV_DONE;
                DIV_DONE:  if (load_div) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready    = (state_q == IDLE) & ~flush & (~valid_q | out_ready);
        accept      = in_valid & in_ready;
        is_div      = is_div_op(in_op);
        div_start   = accept & is_div;
        load_single = accept & ~is_div;
        div_setup   = (state_q == DIV_SETUP);
        div_iter    = (state_q == DIV_ITER);
        // The quotient waits in DIV_DONE rather than overwrite a result still held
        load_div    = (state_q == DIV_DONE) & ~flush & (~valid_q | out_ready);
    end

    div_seq #(.WIDTH(WIDTH)) u_div (
        .clk     (clk),
        .start_i (div_start),
        .setup_i (div_setup),
        .iter_i  (div_iter),
        .sgn_i   (in_op == DIVW),
        .a_i     (in_a),
        .b_i     (in_b),
        .done_o  (div_done),
        .quo_o   (div_quo),
        .exc_o   (div_exc)
    );

    always_comb begin
        valid_d   = valid_q;
        res_d     = res_q;
        cout_d    = cout_q;
        ov_d      = ov_q;
        cr_d      = cr_q;
        tag_d     = tag_q;
        div_tag_d = div_tag_q;
        if (div_start) div_tag_d = in_tag;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_single) begin
            valid_d = 1'b1;
            res_d   = alu_res;
            cout_d  = alu_cout;
            ov_d    = 1'b0;
            cr_d    = alu_cr;
            tag_d   = in_tag;
        end else if (load_div) begin
            valid_d = 1'b1;
            res_d   = div_quo;
            cout_d  = 1'b0;
            ov_d    = div_exc;
            cr_d    = cr_of(div_quo, div_exc);
            tag_d   = div_tag_q;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ov_q    <= 1'b0;
            cr_q    <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ov_q    <= ov_d;
            cr_q    <= cr_d;
            tag_q   <= tag_d;
        end
    end

    always_ff @(posedge clk) div_tag_q <= div_tag_d;

    assign out_valid = valid_q;
    assign out_res   = res_q;
    assign out_cout  = cout_q;
    assign out_ov    = ov_q;
    assign out_cr    = cr_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner cases plus randomized traffic, all
// checked every cycle against a transaction-level model of the ALU.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_cin = 1'b0;
    logic          out_ready = 1'b1;
    logic [4:0]    in_op = '0;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_ready, out_valid, out_cout, out_ov;
    logic [W-1:0]  out_res;
    logic [3:0]    out_cr;
    logic [TW-1:0] out_tag;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rand_on = 1'b0;

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_cout(out_cout), .out_ov(out_ov), .out_cr(out_cr), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0]  res;
        logic          cout;
        logic          ov;
        logic [3:0]    cr;
        logic [TW-1:0] tag;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written straight from the arithmetic definitions
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic [TW-1:0] tag);
        exp_t e;
        logic [W:0] s;
        logic signed [W-1:0] sa, sb;
        logic p;
        e = '0;
        e.tag = tag;
        sa = a;
        sb = b;
        case (op)
            SUB:   begin e.res = a - b; e.cout = (a >= b); end
            NEG:   begin e.res = -a;    e.cout = (a == 0); end
            CMP:   begin e.cr = {sa < sb, sa > sb, a == b, 1'b0}; return e; end
            CMPL:  begin e.cr = {a < b, a > b, a == b, 1'b0};     return e; end
            AND:   e.res = a & b;
            OR:    e.res = a | b;
            XOR:   e.res = a ^ b;
            NAND:  e.res = ~(a & b);
            NOR:   e.res = ~(a | b);
            EQV:   e.res = ~(a ^ b);
            ANDC:  e.res = a & ~b;
            ORC:   e.res = a | ~b;
            POPCNT: for (int j = 0; j < W/8; j++) e.res[8*j +: 8] = 8'($countones(a[8*j +: 8]));
            PRTY: begin
                p = 1'b0;
                for (int j = 0; j < W/8; j++) p = p ^ a[8*j];
                e.res = {31'b0, p};
            end
            CNTLZ: begin
                e.res = W;
                for (int i = W-1; i >= 0; i--) if (a[i]) begin e.res = 32'(W-1-i); break; end
            end
            DIVW:  if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) e.ov = 1'b1;
                   else e.res = W'(sa / sb);
            DIVWU: if (b == 0) e.ov = 1'b1; else e.res = a / b;
            default: begin s = {1'b0, a} + {1'b0, b} + {32'b0, cin}; e.res = s[W-1:0]; e.cout = s[W]; end
        endcase
        e.cr = {$signed(e.res) < 0, $signed(e.res) > 0, e.res == 0, e.ov};
        return e;
    endfunction

    // Cycle-level expectation: result register, divide occupancy and handshake
    exp_t m_out, pend, nv;
    logic m_valid = 1'b0, inflight = 1'b0, exp_rdy, load;
    int   cd = 0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_valid", out_valid, 1'b0);
            chk("reset_data", {out_res, out_cout, out_ov, out_cr, out_tag}, '0);
            chk("reset_in_ready", in_ready, !flush);
            m_valid  = 1'b0;
            inflight = 1'b0;
        end else begin
            exp_rdy = !inflight && !flush && (!m_valid || out_ready);
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) chk("out_data", {out_res, out_cout, out_ov, out_cr, out_tag}, m_out);
            if (flush) begin
                m_valid  = 1'b0;
                inflight = 1'b0;
            end else begin
                load = 1'b0;
                if (inflight) begin
                    if (cd > 1) cd--;
                    else if (!m_valid || out_ready) begin
                        load = 1'b1; nv = pend; inflight = 1'b0;
                    end
                end else if (in_valid && exp_rdy) begin
                    nv = model(in_op, in_a, in_b, in_cin, in_tag);
                    if (in_op == DIVW || in_op == DIVWU) begin
                        inflight = 1'b1; cd = W + 2; pend = nv;
                    end else load = 1'b1;
                end
                if (load) begin m_out = nv; m_valid = 1'b1; end
                else if (m_valid && out_ready) m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin; in_tag = TW'($urandom);
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL issue_timeout: op %0d never accepted", op);
        end
    endtask

    task automatic wait_valid(input string name, input int lat_exp);
        int base, lat;
        base = cyc;
        lat  = -1;
        for (int i = 0; i < 100 && lat < 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = cyc - base;
        end
        chk(name, lat, lat_exp);
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] rop;

    initial begin
        #1 reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;

        chk("pin_add",    model(ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'h0), {32'h0, 1'b1, 1'b0, 4'b0010, 4'h0});
        chk("pin_sub",    model(SUB, 32'd5, 32'd7, 1'b0, 4'h3), {32'hFFFF_FFFE, 1'b0, 1'b0, 4'b1000, 4'h3});
        chk("pin_popcnt", model(POPCNT, 32'h0F03_FF00, 32'h0, 1'b0, 4'h0), {32'h0402_0800, 1'b0, 1'b0, 4'b0100, 4'h0});
        chk("pin_divw",   model(DIVW, 32'hFFFF_FFF9, 32'd2, 1'b0, 4'h0), {32'hFFFF_FFFD, 1'b0, 1'b0, 4'b1000, 4'h0});
        chk("pin_div0",   model(DIVWU, 32'd9, 32'd0, 1'b0, 4'h0), {32'h0, 1'b0, 1'b1, 4'b0011, 4'h0});
        chk("pin_cntlz",  model(CNTLZ, 32'h0001_0000, 32'h0, 1'b0, 4'h0), {32'd15, 1'b0, 1'b0, 4'b0100, 4'h0});
        chk("pin_cmp",    model(CMP, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'h0), {32'h0, 1'b0, 1'b0, 4'b1000, 4'h0});

        issue(ADD, 32'hFFFF_FFFF, 32'h1, 1'b0);
        @(negedge clk);
        chk("add_wrap", {out_valid, out_res, out_cout, out_cr}, {1'b1, 32'h0, 1'b1, 4'b0010});
        step();
        issue(SUB, 32'd5, 32'd7, 1'b0);
        @(negedge clk);
        chk("sub_neg", {out_valid, out_res, out_cr}, {1'b1, 32'hFFFF_FFFE, 4'b1000});
        step();

        repeat (3) issue(POPCNT, 32'h0F03_FF00, 32'h0, 1'b0);
        @(negedge clk);
        chk("popcnt_stream", {out_valid, out_res}, {1'b1, 32'h0402_0800});
        step();

        issue(DIVW, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_valid("divw_latency", W + 2);
        chk("divw_res", {out_res, out_ov, out_cr}, {32'hFFFF_FFFD, 1'b0, 4'b1000});
        step();
        issue(DIVWU, 32'd123, 32'd0, 1'b0);
        wait_valid("div0_latency", W + 2);
        chk("div0_res", {out_res, out_ov, out_cr}, {32'h0, 1'b1, 4'b0011});
        step();
        issue(DIVW, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_valid("divovf_latency", W + 2);
        chk("divovf_res", {out_res, out_ov, out_cr}, {32'h0, 1'b1, 4'b0011});
        step();

        out_ready = 1'b0;
        step();
        issue(ADD, 32'd3, 32'd4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_data", {out_valid, out_res, in_ready}, {1'b1, 32'd8, 1'b0});
            step();
        end
        fork
            issue(XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
            begin step(); step(); out_ready = 1'b1; end
        join
        @(negedge clk);
        chk("release_next", {out_valid, out_res}, {1'b1, 32'h0FF0_0FF0});
        step();

        issue(DIVW, 32'd100, 32'd7, 1'b0);
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", {out_valid, in_ready}, {1'b0, 1'b1});
        step();

        issue(DIVWU, 32'd1000, 32'd3, 1'b0);
        repeat (15) step();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mid_div", out_valid, 1'b0);
        step(); step();
        reset = 1'b1;
        @(negedge clk);
        chk("reset_release_ready", in_ready, 1'b1);
        step();

        rand_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    rop = 5'($urandom_range(31));
                    if ($urandom_range(7) == 0) rop = 5'(16 + $urandom_range(1));
                    issue(rop, rnd_word(), rnd_word(), 1'($urandom_range(1)));
                    if ($urandom_range(3) == 0) step();
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    out_ready = ($urandom_range(3) != 0);
                    flush     = ($urandom_range(47) == 0);
                    step();
                end
            end
        join
        out_ready = 1'b1;
        flush = 1'b0;
        repeat (80) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
